frame_buffer_pp: RTL and testbench

Parametrised single-clock, double-buffered (ping-pong) frame buffer between the camera capture path and the VGA/readout path.
- The writer fills one bank while the reader scans the other.
- Banks swap only when the writer has finished a frame and the reader is at a frame boundary, so no tearing.
- Adds a hardware clear sweep, dropped-frame counting and optional last-address blanking.

---
 rtl/fb_pkg.sv | 18 +
 rtl/frame_buffer_mem.sv | 50 +++++
 rtl/frame_buffer_pp.sv | 172 +++++++++++++++++
 tb/tb_frame_buffer_pp.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared types and helpers for the ping-pong frame buffer.
//   fb_state_e : controller state (normal run / clear sweep)
//   DROP_W     : width of the saturating dropped-frame counter
//   npos()     : words per bank for a given address width
package fb_pkg;

    typedef enum logic [0:0] {
        FB_RUN   = 1'b0,
        FB_CLEAR = 1'b1
    } fb_state_e;

    localparam int DROP_W = 8;

    function automatic int npos(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/frame_buffer_mem.sv
// frame_buffer_mem: single-clock simple dual-port RAM holding both banks.
//   clk            : clock
//   rst            : async active-high reset (output register only)
//   we/waddr/wdata : write port, written on posedge
//   re/raddr       : read port; data appears on rdata after the edge
//   blank          : force the registered read result to zero
//   rdata          : registered read data, holds when re=0
// Reads are read-first: a same-address write in the same cycle returns the
// old word.
module frame_buffer_mem
    import fb_pkg::*;
#(
    parameter int    AW        = 15,
    parameter int    DW        = 12,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW:0]   waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW:0]   raddr,
    input  logic          blank,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 * npos(AW);

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Sampled before this edge's write lands, giving read-first behaviour.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = blank ? '0 : mem[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_pp.sv
// frame_buffer_pp: double-buffered (ping-pong) frame buffer.
//   clk, reset               : clock, async active-high reset
//   wr_en/wr_addr/wr_data    : pixel write into the current write bank
//   wr_frame_done            : writer finished a frame (pulse)
//   rd_en/rd_addr            : pixel read from the current read bank
//   rd_data/rd_valid         : registered read result, valid one cycle later
//   rd_frame_start           : reader at a frame boundary (pulse)
//   clear_req/busy           : start / in-progress hardware clear sweep
//   wr_bank/rd_bank/swap     : bank selects and one-cycle swap pulse
//   drop_cnt                 : saturating count of frames never shown
// Banks exchange only when a finished frame is waiting and the reader is at
// a frame boundary, so the reader never sees a partially written frame.
module frame_buffer_pp
    import fb_pkg::*;
#(
    parameter int            AW             = 15,
    parameter int            DW             = 12,
    parameter int            DOUBLE_BUF     = 1,
    parameter int            CLEAR_ON_RESET = 0,
    parameter logic [DW-1:0] CLEAR_VAL      = '0,
    parameter int            BLANK_LAST     = 1,
    parameter string         INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              wr_frame_done,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    input  logic              rd_frame_start,
    input  logic              clear_req,
    output logic              busy,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              swap,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [0:0] ST_RUN   = FB_RUN;
    localparam logic [0:0] ST_CLEAR = FB_CLEAR;
    localparam logic [0:0] ST_RST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    localparam int          NPOS        = npos(AW);
    localparam logic        DBUF        = (DOUBLE_BUF != 0);
    localparam logic        RD_BANK_RST = DBUF;
    // Single-bank sweep only covers bank 0.
    localparam logic [AW:0] CLR_LAST    = DBUF ? (AW+1)'(2*NPOS-1) : (AW+1)'(NPOS-1);

    logic [0:0]        state_q,    state_d;
    logic [AW:0]       clr_cnt_q,  clr_cnt_d;
    logic              pending_q,  pending_d;
    logic              wr_bank_q,  wr_bank_d;
    logic              rd_bank_q,  rd_bank_d;
    logic              swap_q,     swap_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              run;
    logic              swap_fire;
    logic              mem_we;
    logic [AW:0]       mem_waddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_re;
    logic              mem_blank;

    assign run = (state_q == ST_RUN);

    // A frame finishing this very cycle counts as pending, so a coincident
    // reader boundary swaps immediately. clear_req wins over a swap.
    assign swap_fire = DBUF && run && !clear_req &&
                       (pending_q || wr_frame_done) && rd_frame_start;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        pending_d  = pending_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        drop_cnt_d = drop_cnt_q;
        swap_d     = 1'b0;
        rd_valid_d = run && rd_en;

        if (run) begin
            if (clear_req) begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                pending_d = 1'b0;
            end else if (DBUF) begin
                if (swap_fire) begin
                    wr_bank_d = ~wr_bank_q;
                    rd_bank_d = ~rd_bank_q;
                    pending_d = 1'b0;
                    swap_d    = 1'b1;
                end else if (wr_frame_done) begin
                    // Previous frame never reached the reader: it is lost.
                    pending_d = 1'b1;
                    if (pending_q && drop_cnt_q != '1)
                        drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end else begin
            if (clear_req) begin
                clr_cnt_d = '0;
            end else if (clr_cnt_q == CLR_LAST) begin
                state_d   = ST_RUN;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RST;
            clr_cnt_q  <= '0;
            pending_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= RD_BANK_RST;
            swap_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            pending_q  <= pending_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            swap_q     <= swap_d;
            rd_valid_q <= rd_valid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // The sweep owns the write port; user writes are dropped while clearing.
    always_comb begin
        mem_we    = run ? wr_en : 1'b1;
        mem_waddr = run ? {wr_bank_q, wr_addr} : clr_cnt_q;
        mem_wdata = run ? wr_data : CLEAR_VAL;
    end

    assign mem_re    = run && rd_en;
    assign mem_blank = (BLANK_LAST != 0) && (&rd_addr);

    frame_buffer_mem #(
        .AW        (AW),
        .DW        (DW),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .rst   (reset),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr ({rd_bank_q, rd_addr}),
        .blank (mem_blank),
        .rdata (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign busy     = (state_q == ST_CLEAR);
    assign wr_bank  = wr_bank_q;
    assign rd_bank  = rd_bank_q;
    assign swap     = swap_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_frame_buffer_pp.sv
module tb_frame_buffer_pp;

    localparam int AW = 4;
    localparam int DW = 12;
    localparam int NP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_frame_done = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_frame_start = 1'b0;
    logic          clear_req = 1'b0;
    logic          busy;
    logic          wr_bank;
    logic          rd_bank;
    logic          swap;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    frame_buffer_pp #(
        .AW(AW), .DW(DW), .DOUBLE_BUF(1), .CLEAR_ON_RESET(1),
        .CLEAR_VAL(12'h000), .BLANK_LAST(1), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_frame_start(rd_frame_start), .clear_req(clear_req), .busy(busy),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .swap(swap), .drop_cnt(drop_cnt)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic       busy;
        logic       wb;
        logic       rb;
        logic       sw;
        logic       rv;
        logic [7:0] drop;
        logic [11:0] rd;
    } exp_t;

    exp_t eq[$];

    // Reference model: two banks as plain arrays, frame hand-off bookkeeping.
    logic [11:0] mm [2][NP];
    logic        m_busy, m_wb, m_rb, m_pend;
    int          m_drop, m_clr;
    logic [11:0] m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1; m_wb = 1'b0; m_rb = 1'b1; m_pend = 1'b0;
        m_drop = 0; m_clr = 0; m_rd = 12'h000;
    endtask

    // Advance the model across one rising edge with the inputs now applied.
    task automatic model_step();
        exp_t e;
        logic rv, sw;
        rv = 1'b0; sw = 1'b0;
        if (m_busy) begin
            mm[m_clr / NP][m_clr % NP] = 12'h000;
            if (clear_req)          m_clr = 0;
            else if (m_clr == 2*NP-1) begin m_busy = 1'b0; m_clr = 0; end
            else                    m_clr++;
        end else begin
            if (rd_en) begin
                rv = 1'b1;
                m_rd = (int'(rd_addr) == NP-1) ? 12'h000 : mm[m_rb][rd_addr];
            end
            if (wr_en) mm[m_wb][wr_addr] = wr_data;
            if (clear_req) begin
                m_busy = 1'b1; m_clr = 0; m_pend = 1'b0;
            end else if ((m_pend || wr_frame_done) && rd_frame_start) begin
                sw = 1'b1; m_wb = ~m_wb; m_rb = ~m_rb; m_pend = 1'b0;
            end else if (wr_frame_done) begin
                if (m_pend && m_drop < 255) m_drop++;
                m_pend = 1'b1;
            end
        end
        e.busy = m_busy; e.wb = m_wb; e.rb = m_rb; e.sw = sw; e.rv = rv;
        e.drop = 8'(m_drop); e.rd = m_rd;
        eq.push_back(e);
    endtask

    task automatic cycle(input int we, input int wa, input int wd, input int wfd,
                         input int re, input int ra, input int rfs, input int creq);
        @(negedge clk);
        reset          = 1'b0;
        wr_en          = 1'(we);
        wr_addr        = 4'(wa);
        wr_data        = 12'(wd);
        wr_frame_done  = 1'(wfd);
        rd_en          = 1'(re);
        rd_addr        = 4'(ra);
        rd_frame_start = 1'(rfs);
        clear_req      = 1'(creq);
        model_step();
    endtask

    task automatic idle();            cycle(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic wr(input int a, input int d); cycle(1, a, d, 0, 0, 0, 0, 0); endtask
    task automatic rd(input int a);   cycle(0, 0, 0, 0, 1, a, 0, 0); endtask
    task automatic settle();          @(posedge clk); #2; endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0; wr_frame_done = 1'b0; rd_en = 1'b0;
        rd_frame_start = 1'b0; clear_req = 1'b0;
        #1;
        check("rst_rd_data",  32'(rd_data),  32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_swap",     32'(swap),     32'h0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst_wr_bank",  32'(wr_bank),  32'h0);
        check("rst_rd_bank",  32'(rd_bank),  32'h1);
        check("rst_busy",     32'(busy),     32'h1);
        model_reset();
        eq.delete();
    endtask

    task automatic wait_clear(input string name, input int exp_len);
        int n;
        n = 0;
        do begin
            idle();
            n++;
            settle();
        end while (busy && n < 100);
        if (exp_len > 0) check(name, 32'(n), 32'(exp_len));
        else             check(name, 32'(busy), 32'h0);
    endtask

    // Monitor: one expected record per applied cycle.
    exp_t me, act;
    always @(posedge clk) begin
        #1;
        if (!reset && eq.size() > 0) begin
            me = eq.pop_front();
            act = {busy, wr_bank, rd_bank, swap, rd_valid, drop_cnt, rd_data};
            vectors++;
            if (act !== me) begin
                errors++;
                $display("FAIL cycle_check t=%0t: got busy=%b wb=%b rb=%b swap=%b rv=%b drop=%0d rd=%h expected busy=%b wb=%b rb=%b swap=%b rv=%b drop=%0d rd=%h",
                         $time, act.busy, act.wb, act.rb, act.sw, act.rv, act.drop, act.rd,
                         me.busy, me.wb, me.rb, me.sw, me.rv, me.drop, me.rd);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NP; a++) mm[b][a] = 12'hxxx;
        model_reset();

        // Reset and power-up sweep: busy spans exactly 2*NPOS cycles.
        do_reset();
        wait_clear("clear_len", 2*NP);
        for (int a = 0; a < NP-1; a++) rd(a);
        settle();
        check("t1_last_rd", 32'(rd_data), 32'h000);

        // Write, finish frame, reader boundary two cycles later.
        wr(3, 12'hA5A);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        idle();
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        check("t2_swap",    32'(swap),    32'h1);
        check("t2_wr_bank", 32'(wr_bank), 32'h1);
        check("t2_rd_bank", 32'(rd_bank), 32'h0);
        rd(3);
        settle();
        check("t2_rd_data", 32'(rd_data), 32'hA5A);

        // Coincident frame done and frame start.
        cycle(0, 0, 0, 1, 0, 0, 1, 0);
        settle();
        check("t3_swap", 32'(swap),     32'h1);
        check("t3_drop", 32'(drop_cnt), 32'h0);

        // Last-address blanking.
        wr(15, 12'hFFF);
        wr(14, 12'h5C3);
        cycle(0, 0, 0, 1, 0, 0, 1, 0);
        rd(15);
        settle();
        check("t5_blank_last", 32'(rd_data), 32'h000);
        rd(14);
        settle();
        check("t5_rd_14", 32'(rd_data), 32'h5C3);

        // Dropped frames and saturation.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0, 0, 0, 0);
            idle();
        end
        settle();
        check("t4_drop2",   32'(drop_cnt), 32'h2);
        check("t4_wr_bank", 32'(wr_bank),  32'h1);
        check("t4_rd_bank", 32'(rd_bank),  32'h0);
        for (int i = 0; i < 300; i++) cycle(0, 0, 0, 1, 0, 0, 0, 0);
        settle();
        check("t4_drop_sat", 32'(drop_cnt), 32'hFF);

        // clear_req with pending set; writes and reads issued mid-sweep are
        // ignored (targets already swept, so a leaked write would survive).
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++)
            cycle((i >= 24 && i < 31) ? 1 : 0, i - 24, 12'h700 + i, 0, 1, i % 15, 0, 0);
        wait_clear("t6_sweep_done", 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        check("t6_pending_cleared", 32'(swap), 32'h0);
        cycle(0, 0, 0, 1, 0, 0, 1, 0);
        for (int a = 0; a < 7; a++) rd(a);
        settle();
        check("t6_no_leak", 32'(rd_data), 32'h000);

        // Reset in the middle of a sweep.
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, i, 12'h3C0 + i, 0, 0, 0, 0, 0);
        do_reset();
        wait_clear("t6_reclear_len", 2*NP);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        check("t6_rst_pending", 32'(swap), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0,
                  ($urandom_range(0, 255) == 0) ? 1 : 0);

        idle();
        @(posedge clk);
        #3;
        check("queue_drained", 32'(eq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
